demux8_stream_dispatcher: RTL
=============================

Name: demux8_stream_dispatcher

Overview:
- Sequential front end that sits directly upstream of the 1-to-8 demultiplexer datapath.
- Accepts a valid/ready input stream and decides the destination channel for each word, either taken from the word's address or chosen round-robin over enabled channels.
- Presents each word on a registered output stage as a one-hot valid plus shared data, with a per-channel ready.
- Words addressed to disabled channels are consumed and counted as drops.

Parameters:
- DW, 8, data word width in bits.
- CNTW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = addressed (use in_dest), 1 = round-robin.
- chan_en  input  8  per-channel enable mask, sampled when a word is accepted.
- in_valid  input  1  input word valid.
- in_ready  output  1  dispatcher can accept a word this cycle.
- in_dest  input  3  destination channel, used when mode=0.
- in_data  input  DW  input word.
- out_valid  output  8  one-hot (or zero) valid per channel.
- out_ready  input  8  per-channel ready.
- out_data  output  DW  data of the held word, shared by all channels.
- out_sel  output  3  binary index of the held word's channel (the demux select).
- rr_ptr  output  3  next round-robin start channel.
- drop_cnt  output  CNTW  saturating count of dropped words.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0, drop_cnt=0.
  - in_ready=1 as soon as reset deasserts.
- Definitions:
  - full = |out_valid.
  - drain = full & out_ready[out_sel].
- in_ready = !full | drain. This is combinational, with no dependency on in_valid.
- Accept = in_valid & in_ready.
- Target selection on accept:
  - mode=0: target = in_dest.
  - mode=1: target = first index k in rr_ptr, rr_ptr+1, ... rr_ptr+7 (mod 8) with chan_en[k]=1. Search wraps from 7 to 0.
- Target enabled (chan_en[target]=1):
  - Next cycle out_valid = 1<<target, out_sel = target, out_data = in_data.
  - Latency is 1 cycle from accept to out_valid.
- Target disabled, or mode=1 with chan_en=0:
  - Word is consumed and not presented.
  - drop_cnt increments, saturating at 2^CNTW-1.
  - If drain occurred in the same cycle, output goes empty (out_valid=0).
- rr_ptr: on each accept in mode=1 with a found target, rr_ptr = target+1 (mod 8). It is unchanged in mode=0 and on drops.
- Drain without accept: out_valid clears next cycle. out_data and out_sel hold their last values.
- Simultaneous drain and accept: the new word replaces the old one with no bubble, giving 1 word/cycle sustained throughput.
- Hold rule: while full & !out_ready[out_sel], out_valid, out_data and out_sel are stable, and in_ready=0.
- out_ready bits of channels other than out_sel are ignored.
- mode and chan_en changes take effect at the next accept. A held word is never re-routed or dropped.
- Reset asserted mid-transfer: the held word is discarded immediately and all state returns to reset values.
- No combinational path from in_* to out_*. The only combinational paths are out_ready to in_ready, and out_sel/out_valid to in_ready.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with out_valid=8'h10 -> out_valid=0, drop_cnt=0 and rr_ptr=0 asynchronously; in_ready=1 after release.
- Addressed mode: mode=0, chan_en=8'hFF, send dest 3/data 8'hA5 with out_ready=8'hFF -> one cycle later out_valid=8'h08, out_sel=3, out_data=8'hA5. Back-to-back words 0..7 give one word per cycle with no bubbles.
- Backpressure: hold out_ready[5]=0 with a word for channel 5 held and out_ready of the others at 1 -> in_ready=0 and output stable for 10 cycles. Raising out_ready[5] drains it, with a simultaneous accept of the next word.
- Round-robin with mask: mode=1, chan_en=8'b1010_0110, 6 words, all ready -> out_sel sequence 1,2,5,7,1,2; rr_ptr ends at 3.
- Drops: mode=0, chan_en=8'hFE, 3 words to dest 0 -> no out_valid and drop_cnt=3. mode=1 with chan_en=0 and 300 words (CNTW=8) -> drop_cnt saturates at 255.
- Mask change while held: word held for channel 4, then chan_en[4] cleared -> the word is still delivered on out_valid=8'h10 when out_ready[4]=1.

Source files
------------

// File: rtl/demux8_stream_dispatcher.sv
// Front end for the 1-to-8 demux: routes each word by address or round-robin, drops disabled targets.
// Latency: 1 cycle from accept to out_valid; one registered output word, 1 word/cycle sustained.
// Backpressure: in_ready drops only while the held word's own channel is not ready.
module demux8_stream_dispatcher #(
    parameter int DW   = 8,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [7:0]      chan_en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_dest,
    input  logic [DW-1:0]   in_data,
    output logic [7:0]      out_valid,
    input  logic [7:0]      out_ready,
    output logic [DW-1:0]   out_data,
    output logic [2:0]      out_sel,
    output logic [2:0]      rr_ptr,
    output logic [CNTW-1:0] drop_cnt
);

    logic       full;
    logic       drain;
    logic       accept;
    logic       rr_found;
    logic [2:0] rr_tgt;
    logic [2:0] rr_idx;
    logic [2:0] tgt;
    logic       tgt_en;

    assign full     = |out_valid;
    assign drain    = full & out_ready[out_sel];
    assign in_ready = ~full | drain;
    assign accept   = in_valid & in_ready;

    // Descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        rr_found = 1'b0;
        rr_tgt   = 3'd0;
        rr_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            rr_idx = rr_ptr + 3'(i);
            if (chan_en[rr_idx]) begin
                rr_found = 1'b1;
                rr_tgt   = rr_idx;
            end
        end
    end

    assign tgt    = mode ? rr_tgt : in_dest;
    assign tgt_en = mode ? rr_found : chan_en[in_dest];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 8'd0;
            out_data  <= '0;
            out_sel   <= 3'd0;
            rr_ptr    <= 3'd0;
            drop_cnt  <= '0;
        end else begin
            if (accept && tgt_en) begin
                out_valid <= 8'd1 << tgt;
                out_sel   <= tgt;
                out_data  <= in_data;
            end else if (drain) begin
                out_valid <= 8'd0;
            end

            if (accept && !tgt_en && (drop_cnt != {CNTW{1'b1}}))
                drop_cnt <= drop_cnt + 1'b1;

            if (accept && mode && rr_found)
                rr_ptr <= rr_tgt + 3'd1;
        end
    end

endmodule
